multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the MIPS subset datapath: R-type (add/sub/and/or), lw, sw, beq, bne, j, jal, ori, lui. It replaces the single-cycle opcode decoder with a registered state machine. Instructions execute over 3–5 cycles, and a single shared memory port is used for both instruction fetch and data access. The unit sits between the instruction register's opcode field and every datapath mux and write enable, and it stalls on a ready handshake from memory.

## Interface
- HALT_ON_ILLEGAL, 1: if 1, an unknown opcode parks the FSM in ILLEGAL until reset. If 0, an unknown opcode is a 3-cycle NOP and the FSM returns to FETCH.
- ZERO_EXT_ORI, 1: if 1, `imm_zext` is asserted for ori. If 0, `imm_zext` stays 0 and the immediate is sign-extended.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- opcode  in  6  IR[31:26]; the IR is written only through `ir_write`.
- mem_ready  in  1  memory completes the current request in this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write request (sw only).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load (branch).
- bneq  out  1  branch sense: 1 = take the branch on not-zero.
- pc_source  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = or.
- imm_zext  out  1  zero-extend the immediate.
- lui  out  1  write-back data select: imm<<16.
- reg_dst  out  2  destination register: 00 = rt, 01 = rd, 10 = r31.
- mem_to_reg  out  1  write-back data select: MDR.
- reg_write  out  1  register file write enable.
- illegal  out  1  unknown opcode decoded.
- state  out  4  current state (debug).

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - REX = 6, RWB = 7, BR = 8, JMP = 9, JALS = 10
  - IEX = 11, IWB = 12, LUIS = 13, ILLEGAL = 14
  - Code 15 is unused and recovers to FETCH.
- Outputs are Moore decodes of `state`, with two exceptions gated by `mem_ready`:
  - `ir_write` and `pc_write` in FETCH.
- Unlisted outputs are 0 in every state.

Per-state outputs and transitions:
- FETCH:
  - Outputs: mem_req, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00; ir_write = pc_write = mem_ready.
  - Transition: stay while !mem_ready; go to DECODE on mem_ready.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, alu_op = 00 (branch target into ALUOut).
  - Transition on opcode: 000000 → REX, 100011/101011 → MEMADR, 000100/000101 → BR, 000010 → JMP, 000011 → JALS, 001101 → IEX, 001111 → LUIS, any other → ILLEGAL.
- MEMADR:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 00.
  - Transition: → MEMRD for lw, → MEMWR for sw.
- MEMRD:
  - Outputs: mem_req, iord = 1.
  - Transition: stay while !mem_ready; → MEMWB on mem_ready.
- MEMWB:
  - Outputs: reg_write, reg_dst = 00, mem_to_reg.
  - Transition: → FETCH.
- MEMWR:
  - Outputs: mem_req, mem_we, iord = 1.
  - Transition: stay while !mem_ready; → FETCH on mem_ready.
- REX:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - Transition: → RWB.
- RWB:
  - Outputs: reg_write, reg_dst = 01.
  - Transition: → FETCH.
- BR:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond, pc_source = 01; bneq = opcode[0].
  - Transition: → FETCH.
- JMP:
  - Outputs: pc_write, pc_source = 10.
  - Transition: → FETCH.
- JALS:
  - Outputs: pc_write, pc_source = 10, reg_write, reg_dst = 10. The return address is PC+4, already in PC.
  - Transition: → FETCH.
- IEX:
  - Outputs: alu_src_a = 1, alu_src_b = 10, alu_op = 11, imm_zext = ZERO_EXT_ORI.
  - Transition: → IWB.
- IWB:
  - Outputs: reg_write, reg_dst = 00, imm_zext = ZERO_EXT_ORI.
  - Transition: → FETCH.
- LUIS:
  - Outputs: reg_write, reg_dst = 00, lui.
  - Transition: → FETCH.
- ILLEGAL:
  - Outputs: illegal = 1; no writes.
  - Transition: stay if HALT_ON_ILLEGAL = 1; otherwise → FETCH.
- Opcode use: opcode is sampled only in DECODE, MEMADR and BR. The IR must not change outside FETCH.

## Timing
- Reset:
  - rst_n low at a rising edge sets state to FETCH. This takes priority over every transition, including mid-access and ILLEGAL.
  - While rst_n is low, every output is forced to 0 (gated by rst_n), including mem_req.
  - The first fetch request is issued in the cycle after rst_n goes high.
- Cycle counts with zero wait states (mem_ready = 1 on the first request cycle):
  - beq, bne, j, jal, lui: 3 cycles.
  - R-type, ori, sw: 4 cycles.
  - lw: 5 cycles.
  - Illegal opcode with HALT_ON_ILLEGAL = 0: 3 cycles.
- Wait states: each cycle of mem_ready low in FETCH, MEMRD or MEMWR adds one cycle. During a wait, mem_req, mem_we and iord are held constant.
- `mem_ready` is ignored in all other states.
- Register-file and PC writes are single-cycle pulses. Exactly one reg_write pulse is issued per register-writing instruction, and no write enable is asserted in DECODE.

## Test plan
- rst_n low for 2 cycles with mem_ready = 1 → all outputs 0. One cycle after release: state = 0, mem_req = 1, ir_write = 1.
- lw (opcode 100011), mem_ready held low for 2 cycles in MEMRD → state sequence 0,1,2,3,3,3,4,0. reg_write is high only in state 4, with mem_to_reg = 1 and reg_dst = 00.
- bne (000101) → states 0,1,8. In state 8: pc_write_cond = 1, bneq = 1, alu_op = 01, pc_source = 01. beq (000100) gives bneq = 0.
- jal (000011) → 3 cycles. State 10: pc_write = 1, reg_write = 1, reg_dst = 10, pc_source = 10.
- ori (001101) with ZERO_EXT_ORI = 1 → IEX: alu_op = 11, imm_zext = 1; IWB: reg_write = 1, reg_dst = 00. lui (001111) → state 13 with lui = 1 and reg_write = 1.
- Opcode 111111:
  - HALT_ON_ILLEGAL = 1 → state holds at 14 with illegal = 1. Asserting rst_n = 0 returns the FSM to 0.
  - HALT_ON_ILLEGAL = 0 → state returns to 0 after one cycle in 14, with no write enables asserted.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath/memory bundle: opcode and memory handshake in,
// every datapath mux select and write enable out.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       bneq;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       imm_zext;
  logic       lui;
  logic [1:0] reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  // control unit side
  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, bneq,
           pc_source, alu_src_a, alu_src_b, alu_op, imm_zext, lui, reg_dst,
           mem_to_reg, reg_write, illegal, state
  );

  // datapath / memory side
  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, bneq,
           pc_source, alu_src_a, alu_src_b, alu_op, imm_zext, lui, reg_dst,
           mem_to_reg, reg_write, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control FSM. Moore outputs decoded from the state
// register; only the FETCH-cycle IR/PC loads look at mem_ready. All outputs
// are held at 0 while rst_n is low.
module multicycle_control #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter bit ZERO_EXT_ORI    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_REX     = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BR      = 4'd8;
  localparam logic [3:0] S_JMP     = 4'd9;
  localparam logic [3:0] S_JALS    = 4'd10;
  localparam logic [3:0] S_IEX     = 4'd11;
  localparam logic [3:0] S_IWB     = 4'd12;
  localparam logic [3:0] S_LUIS    = 4'd13;
  localparam logic [3:0] S_ILLEGAL = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  logic [3:0] state_q, state_d;

  // state register; reset wins over any transition, including ILLEGAL
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // next-state: opcode only matters in DECODE/MEMADR, mem_ready only in memory states
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:      state_d = S_REX;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:          state_d = S_JMP;
          OP_JAL:        state_d = S_JALS;
          OP_ORI:        state_d = S_IEX;
          OP_LUI:        state_d = S_LUIS;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
      S_REX:     state_d = S_RWB;
      S_IEX:     state_d = S_IWB;
      S_MEMWB, S_RWB, S_BR, S_JMP, S_JALS, S_IWB, S_LUIS: state_d = S_FETCH;
      S_ILLEGAL: state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      default:   state_d = S_FETCH;  // unused code 15 recovers
    endcase
  end

  // output decode; everything forced low while in reset
  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.iord          = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.bneq          = 1'b0;
    bus.pc_source     = 2'b00;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.imm_zext      = 1'b0;
    bus.lui           = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.illegal       = 1'b0;
    bus.state         = rst_n ? state_q : 4'd0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_src_b = 2'b01;
          // IR and PC+4 land together on the cycle the fetch completes
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        S_DECODE: bus.alu_src_b = 2'b11;  // branch target into ALUOut
        S_MEMADR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        S_MEMWB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
          bus.iord    = 1'b1;
        end
        S_REX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_op    = 2'b10;
        end
        S_RWB: begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = 2'b01;
        end
        S_BR: begin
          bus.alu_src_a     = 1'b1;
          bus.alu_op        = 2'b01;
          bus.pc_write_cond = 1'b1;
          bus.pc_source     = 2'b01;
          bus.bneq          = bus.opcode[0];  // bne = 000101, beq = 000100
        end
        S_JMP: begin
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
        end
        S_JALS: begin
          // PC already holds PC+4, so r31 gets it while PC takes the jump target
          bus.pc_write  = 1'b1;
          bus.pc_source = 2'b10;
          bus.reg_write = 1'b1;
          bus.reg_dst   = 2'b10;
        end
        S_IEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = 2'b11;
          bus.imm_zext  = ZERO_EXT_ORI;
        end
        S_IWB: begin
          bus.reg_write = 1'b1;
          bus.imm_zext  = ZERO_EXT_ORI;
        end
        S_LUIS: begin
          bus.reg_write = 1'b1;
          bus.lui       = 1'b1;
        end
        S_ILLEGAL: bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (halt/zext on, and both off)
// run in lockstep against a trace model built from instruction classes.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, bneq;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       imm_zext, lui;
    logic [1:0] reg_dst;
    logic       mem_to_reg, reg_write, illegal;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    int         wf, wm;   // wait cycles in FETCH and in the memory phase
    int         cycles;   // expected instruction length
    int         rw;       // expected reg_write pulses
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  int         nvec = 0, nerr = 0;

  multicycle_control_if if1 ();
  multicycle_control_if if2 ();
  assign if1.opcode = opcode;  assign if1.mem_ready = mem_ready;
  assign if2.opcode = opcode;  assign if2.mem_ready = mem_ready;

  multicycle_control #(.HALT_ON_ILLEGAL(1'b1), .ZERO_EXT_ORI(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));
  multicycle_control #(.HALT_ON_ILLEGAL(1'b0), .ZERO_EXT_ORI(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.master));

  always #5 clk = ~clk;

  outs_t a1, a2;
  assign a1 = {if1.mem_req, if1.mem_we, if1.iord, if1.ir_write, if1.pc_write,
               if1.pc_write_cond, if1.bneq, if1.pc_source, if1.alu_src_a,
               if1.alu_src_b, if1.alu_op, if1.imm_zext, if1.lui, if1.reg_dst,
               if1.mem_to_reg, if1.reg_write, if1.illegal};
  assign a2 = {if2.mem_req, if2.mem_we, if2.iord, if2.ir_write, if2.pc_write,
               if2.pc_write_cond, if2.bneq, if2.pc_source, if2.alu_src_a,
               if2.alu_src_b, if2.alu_op, if2.imm_zext, if2.lui, if2.reg_dst,
               if2.mem_to_reg, if2.reg_write, if2.illegal};

  outs_t      tab [16];   // per-state Moore outputs from the control table
  logic [3:0] trace[$];   // expected state per cycle
  logic       rdy[$];     // mem_ready to drive per cycle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic outs_t expo(input logic [3:0] st, input logic mr,
                                 input logic [5:0] op, input bit z);
    outs_t e = tab[st];
    if (st == 4'd0) begin e.ir_write = mr; e.pc_write = mr; end
    if (st == 4'd8) e.bneq = op[0];
    if (st == 4'd11 || st == 4'd12) e.imm_zext = z;
    return e;
  endfunction

  function automatic bit is_writer(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b000011, 6'b001101, 6'b001111};
  endfunction

  task automatic push(input logic [3:0] s, input logic r);
    trace.push_back(s); rdy.push_back(r);
  endtask

  // instruction -> expected state walk, with wait cycles where memory stalls
  task automatic build(input logic [5:0] op, input int wf, input int wm);
    trace.delete(); rdy.delete();
    for (int i = 0; i < wf; i++) push(4'd0, 1'b0);
    push(4'd0, 1'b1);
    push(4'd1, 1'($urandom));
    case (op)
      6'b100011: begin
        push(4'd2, 1'($urandom));
        for (int i = 0; i < wm; i++) push(4'd3, 1'b0);
        push(4'd3, 1'b1); push(4'd4, 1'($urandom));
      end
      6'b101011: begin
        push(4'd2, 1'($urandom));
        for (int i = 0; i < wm; i++) push(4'd5, 1'b0);
        push(4'd5, 1'b1);
      end
      6'b000000: begin push(4'd6, 1'($urandom)); push(4'd7, 1'($urandom)); end
      6'b000100, 6'b000101: push(4'd8, 1'($urandom));
      6'b000010: push(4'd9, 1'($urandom));
      6'b000011: push(4'd10, 1'($urandom));
      6'b001101: begin push(4'd11, 1'($urandom)); push(4'd12, 1'($urandom)); end
      6'b001111: push(4'd13, 1'($urandom));
      default:   push(4'd14, 1'($urandom));
    endcase
  endtask

  task automatic cyc_check(input logic [3:0] e1, input logic [3:0] e2);
    chk("state1", 32'(if1.state), 32'(e1));
    chk("outs1", 32'(a1), 32'(expo(e1, mem_ready, opcode, 1'b1)));
    chk("state2", 32'(if2.state), 32'(e2));
    chk("outs2", 32'(a2), 32'(expo(e2, mem_ready, opcode, 1'b0)));
  endtask

  // one instruction from FETCH; ends with a stalled FETCH cycle to confirm return
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           input int exp_cyc, input int exp_rw);
    int rw = 0, dcyc = -1;
    bit seen_nz = 0;
    build(op, wf, wm);
    opcode = op;
    for (int k = 0; k < trace.size(); k++) begin
      mem_ready = rdy[k];
      @(negedge clk);
      cyc_check(trace[k], trace[k]);
      if (if1.state != 4'd0) seen_nz = 1;
      else if (seen_nz && dcyc < 0) dcyc = k;
      if (if1.reg_write) rw++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    cyc_check(4'd0, 4'd0);
    if (dcyc < 0 && if1.state == 4'd0) dcyc = trace.size();
    chk($sformatf("cycles op=%b", op), 32'(dcyc), 32'(exp_cyc));
    chk($sformatf("regwr op=%b", op), 32'(rw), 32'(exp_rw));
    @(posedge clk); #1;
  endtask

  vec_t vecs[12];
  logic [5:0] legal[10];

  initial begin
    foreach (tab[i]) tab[i] = '0;
    tab[0].mem_req = 1; tab[0].alu_src_b = 2'b01;
    tab[1].alu_src_b = 2'b11;
    tab[2].alu_src_a = 1; tab[2].alu_src_b = 2'b10;
    tab[3].mem_req = 1; tab[3].iord = 1;
    tab[4].reg_write = 1; tab[4].mem_to_reg = 1;
    tab[5].mem_req = 1; tab[5].mem_we = 1; tab[5].iord = 1;
    tab[6].alu_src_a = 1; tab[6].alu_op = 2'b10;
    tab[7].reg_write = 1; tab[7].reg_dst = 2'b01;
    tab[8].alu_src_a = 1; tab[8].alu_op = 2'b01; tab[8].pc_write_cond = 1; tab[8].pc_source = 2'b01;
    tab[9].pc_write = 1; tab[9].pc_source = 2'b10;
    tab[10].pc_write = 1; tab[10].pc_source = 2'b10; tab[10].reg_write = 1; tab[10].reg_dst = 2'b10;
    tab[11].alu_src_a = 1; tab[11].alu_src_b = 2'b10; tab[11].alu_op = 2'b11; tab[11].imm_zext = 1;
    tab[12].reg_write = 1; tab[12].imm_zext = 1;
    tab[13].reg_write = 1; tab[13].lui = 1;
    tab[14].illegal = 1;

    vecs[0]  = '{6'b100011, 0, 2, 7, 1};
    vecs[1]  = '{6'b100011, 0, 0, 5, 1};
    vecs[2]  = '{6'b101011, 0, 0, 4, 0};
    vecs[3]  = '{6'b101011, 1, 1, 6, 0};
    vecs[4]  = '{6'b000000, 0, 0, 4, 1};
    vecs[5]  = '{6'b000100, 0, 0, 3, 0};
    vecs[6]  = '{6'b000101, 0, 0, 3, 0};
    vecs[7]  = '{6'b000010, 0, 0, 3, 0};
    vecs[8]  = '{6'b000011, 0, 0, 3, 1};
    vecs[9]  = '{6'b001101, 0, 0, 4, 1};
    vecs[10] = '{6'b001111, 0, 0, 3, 1};
    vecs[11] = '{6'b000000, 2, 0, 6, 1};
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
              6'b000010, 6'b000011, 6'b001101, 6'b001111, 6'b100011};

    // reset held two cycles with mem_ready high: everything low
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_outs1", 32'(a1), 32'd0);  chk("rst_state1", 32'(if1.state), 32'd0);
      chk("rst_outs2", 32'(a2), 32'd0);  chk("rst_state2", 32'(if2.state), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].wf, vecs[i].wm, vecs[i].cycles, vecs[i].rw);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] op = legal[$urandom_range(9)];
      int wf = $urandom_range(2), wm = $urandom_range(2);
      build(op, wf, wm);
      run_instr(op, wf, wm, trace.size(), is_writer(op) ? 1 : 0);
    end

    // reset in the middle of a stalled load read
    opcode = 6'b100011;
    mem_ready = 1'b1; @(negedge clk); cyc_check(4'd0, 4'd0); @(posedge clk); #1;
    @(negedge clk); cyc_check(4'd1, 4'd1); @(posedge clk); #1;
    @(negedge clk); cyc_check(4'd2, 4'd2); @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk); cyc_check(4'd3, 4'd3); @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_outs1", 32'(a1), 32'd0); chk("midrst_outs2", 32'(a2), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); cyc_check(4'd0, 4'd0); @(posedge clk); #1;

    // unknown opcode: instance 1 parks, instance 2 falls back to FETCH
    opcode = 6'b111111; mem_ready = 1'b1;
    @(negedge clk); cyc_check(4'd0, 4'd0); @(posedge clk); #1;
    @(negedge clk); cyc_check(4'd1, 4'd1); @(posedge clk); #1;
    @(negedge clk); cyc_check(4'd14, 4'd14); @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); cyc_check(4'd14, 4'd0); @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("illrst_outs1", 32'(a1), 32'd0); chk("illrst_state1", 32'(if1.state), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); cyc_check(4'd0, 4'd0); @(posedge clk); #1;

    run_instr(6'b001101, 0, 0, 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
